// File: rtl/rrb_requester_ctrl_if.sv
// Requester/arbiter handshake bundle for rrb_requester_ctrl.
// master: the requester controller; slave: job source / arbiter side.
`timescale 1ns/1ps
interface rrb_requester_ctrl_if #(
  parameter int N = 4
);
  localparam int CH_W = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]    job_in;
  logic [N-1:0]    grant;
  logic [N-1:0]    req;
  logic            xfer_valid;
  logic [CH_W-1:0] xfer_ch;
  logic            xfer_last;
  logic [N-1:0]    done;
  logic [N-1:0]    full;
  logic [N-1:0]    drop;
  logic            grant_err;

  modport master (
    input  job_in, grant,
    output req, xfer_valid, xfer_ch, xfer_last, done, full, drop, grant_err
  );

  modport slave (
    output job_in, grant,
    input  req, xfer_valid, xfer_ch, xfer_last, done, full, drop, grant_err
  );
endinterface

// File: rtl/rrb_requester_ctrl.sv
// Round-robin requester controller: per-channel pending-job counters feed
// req to an external arbiter; a granted channel gets a BURST_LEN-beat
// transfer followed by a one-cycle RELEASE that retires one job.
`timescale 1ns/1ps
module rrb_requester_ctrl #(
  parameter int N         = 4,
  parameter int BURST_LEN = 4,
  parameter int CNT_W     = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  rrb_requester_ctrl_if.master bus
);
  localparam int CH_W   = (N > 1) ? $clog2(N) : 1;
  localparam int BEAT_W = 4;
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

  typedef enum logic [1:0] {IDLE, XFER, RELEASE} state_t;

  state_t            state;
  logic [CH_W-1:0]   sel;
  logic [BEAT_W-1:0] beat;
  logic [CNT_W-1:0]  pending [N];
  logic [N-1:0]      done_q;
  logic [N-1:0]      drop_q;
  logic              gerr_q;

  logic [N-1:0]      req_c;
  logic [N-1:0]      full_c;
  logic [N-1:0]      dec;
  logic [CH_W-1:0]   grant_idx;
  logic              grant_onehot;
  logic              grant_hit;

  // Register-only decodes: request mask, full flags, RELEASE decrement select
  always_comb begin
    req_c  = '0;
    full_c = '0;
    dec    = '0;
    for (int unsigned i = 0; i < N; i++) begin
      req_c[i]  = (pending[i] != '0) && !((state != IDLE) && (sel == CH_W'(i)));
      full_c[i] = (pending[i] == CNT_MAX);
      dec[i]    = (state == RELEASE) && (sel == CH_W'(i));
    end
  end

  // Grant qualification: one-hot check, hit against current requests, index encode
  always_comb begin
    grant_idx = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (bus.grant[i]) grant_idx = grant_idx | CH_W'(i);
    end
    grant_onehot = (bus.grant != '0) && ((bus.grant & (bus.grant - N'(1))) == '0);
    grant_hit    = (bus.grant & req_c) != '0;
  end

  // Pending counters: simultaneous job and retire cancel; saturate and flag drops
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < N; i++) pending[i] <= '0;
      drop_q <= '0;
    end else begin
      for (int unsigned i = 0; i < N; i++) begin
        drop_q[i] <= 1'b0;
        if (bus.job_in[i] && !dec[i]) begin
          if (full_c[i]) drop_q[i] <= 1'b1;
          else           pending[i] <= pending[i] + CNT_W'(1);
        end else if (dec[i] && !bus.job_in[i]) begin
          pending[i] <= pending[i] - CNT_W'(1);
        end
      end
    end
  end

  // Control FSM; done is registered on the last beat so it shows during RELEASE
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      sel    <= '0;
      beat   <= '0;
      done_q <= '0;
      gerr_q <= 1'b0;
    end else begin
      done_q <= '0;
      gerr_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.grant != '0) begin
            if (grant_onehot && grant_hit) begin
              sel   <= grant_idx;
              beat  <= '0;
              state <= XFER;
            end else begin
              gerr_q <= 1'b1;
            end
          end
        end
        XFER: begin
          beat <= beat + BEAT_W'(1);
          if (beat == LAST_BEAT) begin
            state  <= RELEASE;
            done_q <= N'(1) << sel;
          end
        end
        RELEASE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req        = req_c;
  assign bus.full       = full_c;
  assign bus.xfer_valid = (state == XFER);
  assign bus.xfer_ch    = sel;
  assign bus.xfer_last  = (state == XFER) && (beat == LAST_BEAT);
  assign bus.done       = done_q;
  assign bus.drop       = drop_q;
  assign bus.grant_err  = gerr_q;

endmodule

// File: tb/tb_rrb_requester_ctrl.sv
// Directed bench for rrb_requester_ctrl (N=4, BURST_LEN=4, CNT_W=3).
// Inputs change and outputs are sampled on the falling clock edge.
`timescale 1ns/1ps
module tb_rrb_requester_ctrl;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_pass;

  rrb_requester_ctrl_if #(.N(4)) bus ();

  rrb_requester_ctrl #(.N(4), .BURST_LEN(4), .CNT_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] job;
    logic [3:0] grant;
    logic [3:0] req;
    logic       xv;
    logic [1:0] xch;
    logic       xl;
    logic [3:0] done;
    logic [3:0] full;
    logic [3:0] drop;
    logic       gerr;
  } vec_t;

  vec_t tbl [17];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    bus.job_in = '0;
    bus.grant  = '0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst.req",  32'(bus.req), 0);
    chk("rst.xv",   32'(bus.xfer_valid), 0);
    chk("rst.xch",  32'(bus.xfer_ch), 0);
    chk("rst.xl",   32'(bus.xfer_last), 0);
    chk("rst.done", 32'(bus.done), 0);
    chk("rst.full", 32'(bus.full), 0);
    chk("rst.drop", 32'(bus.drop), 0);
    chk("rst.gerr", 32'(bus.grant_err), 0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Starts and ends on a falling edge with the FSM idle.
  task automatic run_burst(input string nm, input logic [3:0] g, input logic [1:0] ch);
    bus.grant = g;
    step();
    bus.grant = '0;
    for (int b = 0; b < 4; b++) begin
      chk($sformatf("%s.b%0d.xv", nm, b),  32'(bus.xfer_valid), 1);
      chk($sformatf("%s.b%0d.xch", nm, b), 32'(bus.xfer_ch), 32'(ch));
      chk($sformatf("%s.b%0d.xl", nm, b),  32'(bus.xfer_last), (b == 3) ? 1 : 0);
      step();
    end
    chk($sformatf("%s.done", nm), 32'(bus.done), 32'(4'b0001 << ch));
    chk($sformatf("%s.relxv", nm), 32'(bus.xfer_valid), 0);
    step();
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] xv_trace;
    int bursts;
    n_checks = 0;
    n_pass   = 0;
    reset    = 1'b1;
    bus.job_in = '0;
    bus.grant  = '0;

    //           job      grant    req      xv  xch   xl  done     full     drop     gerr
    tbl[0]  = '{4'b0001, 4'b0000, 4'b0001, 0, 2'd0, 0, 4'b0000, 4'b0000, 4'b0000, 0};
    tbl[1]  = '{4'b0000, 4'b0001, 4'b0000, 1, 2'd0, 0, 4'b0000, 4'b0000, 4'b0000, 0};
    tbl[2]  = '{4'b0000, 4'b0000, 4'b0000, 1, 2'd0, 0, 4'b0000, 4'b0000, 4'b0000, 0};
    tbl[3]  = '{4'b0000, 4'b0000, 4'b0000, 1, 2'd0, 0, 4'b0000, 4'b0000, 4'b0000, 0};
    tbl[4]  = '{4'b0000, 4'b0000, 4'b0000, 1, 2'd0, 1, 4'b0000, 4'b0000, 4'b0000, 0};
    tbl[5]  = '{4'b0000, 4'b0000, 4'b0000, 0, 2'd0, 0, 4'b0001, 4'b0000, 4'b0000, 0};
    tbl[6]  = '{4'b0000, 4'b0000, 4'b0000, 0, 2'd0, 0, 4'b0000, 4'b0000, 4'b0000, 0};
    tbl[7]  = '{4'b0010, 4'b0000, 4'b0010, 0, 2'd0, 0, 4'b0000, 4'b0000, 4'b0000, 0};
    tbl[8]  = '{4'b0000, 4'b0110, 4'b0010, 0, 2'd0, 0, 4'b0000, 4'b0000, 4'b0000, 1};
    tbl[9]  = '{4'b0000, 4'b1000, 4'b0010, 0, 2'd0, 0, 4'b0000, 4'b0000, 4'b0000, 1};
    tbl[10] = '{4'b0000, 4'b0000, 4'b0010, 0, 2'd0, 0, 4'b0000, 4'b0000, 4'b0000, 0};
    tbl[11] = '{4'b0000, 4'b0010, 4'b0000, 1, 2'd1, 0, 4'b0000, 4'b0000, 4'b0000, 0};
    tbl[12] = '{4'b0000, 4'b1111, 4'b0000, 1, 2'd1, 0, 4'b0000, 4'b0000, 4'b0000, 0};
    tbl[13] = '{4'b1000, 4'b0000, 4'b1000, 1, 2'd1, 0, 4'b0000, 4'b0000, 4'b0000, 0};
    tbl[14] = '{4'b0000, 4'b0000, 4'b1000, 1, 2'd1, 1, 4'b0000, 4'b0000, 4'b0000, 0};
    tbl[15] = '{4'b0000, 4'b0000, 4'b1000, 0, 2'd1, 0, 4'b0010, 4'b0000, 4'b0000, 0};
    tbl[16] = '{4'b0000, 4'b0000, 4'b1000, 0, 2'd1, 0, 4'b0000, 4'b0000, 4'b0000, 0};

    // Table: single burst, illegal grants, grant ignored mid-burst, other channel queueing
    do_reset();
    for (int r = 0; r < 17; r++) begin
      bus.job_in = tbl[r].job;
      bus.grant  = tbl[r].grant;
      step();
      chk($sformatf("row%0d.req", r),  32'(bus.req), 32'(tbl[r].req));
      chk($sformatf("row%0d.xv", r),   32'(bus.xfer_valid), 32'(tbl[r].xv));
      if (tbl[r].xv) chk($sformatf("row%0d.xch", r), 32'(bus.xfer_ch), 32'(tbl[r].xch));
      chk($sformatf("row%0d.xl", r),   32'(bus.xfer_last), 32'(tbl[r].xl));
      chk($sformatf("row%0d.done", r), 32'(bus.done), 32'(tbl[r].done));
      chk($sformatf("row%0d.full", r), 32'(bus.full), 32'(tbl[r].full));
      chk($sformatf("row%0d.drop", r), 32'(bus.drop), 32'(tbl[r].drop));
      chk($sformatf("row%0d.gerr", r), 32'(bus.grant_err), 32'(tbl[r].gerr));
    end
    bus.job_in = '0;
    bus.grant  = '0;

    // Saturation: 7 jobs fill channel 2, the 8th drops, exactly 7 bursts drain it
    do_reset();
    for (int p = 0; p < 7; p++) begin
      bus.job_in = 4'b0100;
      step();
      chk($sformatf("s2.p%0d.full", p), 32'(bus.full), (p == 6) ? 32'h4 : 32'h0);
      chk($sformatf("s2.p%0d.drop", p), 32'(bus.drop), 0);
    end
    bus.job_in = 4'b0100;
    step();
    bus.job_in = '0;
    chk("s2.p7.drop", 32'(bus.drop), 32'h4);
    chk("s2.p7.full", 32'(bus.full), 32'h4);
    step();
    chk("s2.drop_clr", 32'(bus.drop), 0);
    bursts = 0;
    for (int b = 0; b < 20; b++) begin
      if (bus.req[2] !== 1'b1) break;
      run_burst($sformatf("s2.d%0d", b), 4'b0100, 2'd2);
      bursts++;
    end
    chk("s2.bursts", 32'(bursts), 7);

    // Job arriving in the RELEASE cycle cancels the decrement
    do_reset();
    bus.job_in = 4'b0010;
    step();
    bus.job_in = '0;
    bus.grant  = 4'b0010;
    step();
    bus.grant  = '0;
    chk("s3.req_drop", 32'(bus.req), 0);
    for (int b = 0; b < 4; b++) step();
    chk("s3.done", 32'(bus.done), 32'h2);
    bus.job_in = 4'b0010;
    step();
    bus.job_in = '0;
    chk("s3.req_back", 32'(bus.req), 32'h2);
    run_burst("s3.b", 4'b0010, 2'd1);
    chk("s3.req_empty", 32'(bus.req), 0);

    // Back-to-back bursts: channel 3 then channel 0 granted in the first IDLE cycle
    do_reset();
    bus.job_in = 4'b1001;
    step();
    bus.job_in = '0;
    bus.grant  = 4'b1000;
    step();
    xv_trace = '0;
    for (int k = 0; k < 10; k++) begin
      xv_trace[k] = bus.xfer_valid;
      if (k == 0) chk("s5.xch3", 32'(bus.xfer_ch), 3);
      if (k == 4) chk("s5.done3", 32'(bus.done), 32'h8);
      if (k == 5) chk("s5.req_idle", 32'(bus.req), 32'h1);
      if (k == 6) chk("s5.xch0", 32'(bus.xfer_ch), 0);
      bus.grant = (k == 5) ? 4'b0001 : 4'b0000;
      step();
    end
    chk("s5.xv_trace", 32'(xv_trace), 32'b1111001111);
    chk("s5.done0", 32'(bus.done), 32'h1);

    // Asynchronous reset on the second beat aborts the burst and clears queues
    do_reset();
    bus.job_in = 4'b0011;
    step();
    bus.job_in = 4'b0001;
    step();
    bus.job_in = '0;
    bus.grant  = 4'b0001;
    step();
    bus.grant  = '0;
    chk("s6.beat1", 32'(bus.xfer_valid), 1);
    @(posedge clk);
    #2;
    chk("s6.beat2", 32'(bus.xfer_valid), 1);
    reset = 1'b0;
    #1;
    chk("s6.xv_async", 32'(bus.xfer_valid), 0);
    chk("s6.req_async", 32'(bus.req), 0);
    @(negedge clk);
    chk("s6.done_rst", 32'(bus.done), 0);
    reset = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      chk($sformatf("s6.c%0d.done", c), 32'(bus.done), 0);
      chk($sformatf("s6.c%0d.req", c), 32'(bus.req), 0);
      chk($sformatf("s6.c%0d.xv", c), 32'(bus.xfer_valid), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/rrb_requester_ctrl.md
RRB_REQUESTER_CTRL -- requirements
Module: rrb_requester_ctrl

Interface
REQ-001 Parameter N, default 4: number of requester channels.
REQ-002 Parameter BURST_LEN, default 4: beats per granted transfer (legal range 1..16).
REQ-003 Parameter CNT_W, default 3: width of each per-channel pending-job counter (max value 2^CNT_W-1).
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset; reset=0 clears all state immediately, independent of clk.
REQ-006 job_in  in  N  per-channel job pulse; each high bit adds one pending job to that channel in that cycle.
REQ-007 grant  in  N  one-hot grant from the round-robin arbiter.
REQ-008 req  out  N  per-channel request to the arbiter.
REQ-009 xfer_valid  out  1  high for each transfer beat.
REQ-010 xfer_ch  out  clog2(N)  index of the channel being serviced; valid while xfer_valid=1.
REQ-011 xfer_last  out  1  high on the final beat of a burst.
REQ-012 done  out  N  one-cycle pulse on a channel when its burst completes.
REQ-013 full  out  N  channel pending counter equals its maximum value.
REQ-014 drop  out  N  one-cycle pulse when job_in arrives on a full channel and is not absorbed by that cycle's decrement.
REQ-015 grant_err  out  1  one-cycle pulse when an illegal grant is seen in IDLE.

Function
REQ-016 FSM states: IDLE, XFER and RELEASE; the FSM is encoded in registers.
REQ-017 Channel i pending counter: +1 on job_in[i]; -1 in RELEASE when sel=i; both events in the same cycle leave the counter unchanged.
REQ-018 Counter saturates at max: a job_in on a full channel with no decrement in that cycle leaves the count unchanged and pulses drop[i] in the next cycle.
REQ-019 req[i] = (pending[i]!=0) AND NOT (state!=IDLE AND sel==i); the logic is combinational from registers only, with no path from any input.
REQ-020 IDLE: if grant is exactly one-hot and grant&req is nonzero, latch sel=index(grant), clear the beat counter, and go to XFER next cycle.
REQ-021 IDLE: if grant is nonzero but not one-hot, or grant&req==0, ignore the grant, stay in IDLE, and pulse grant_err next cycle.
REQ-022 IDLE with grant==0: stay in IDLE with no error.
REQ-023 XFER: xfer_valid=1 and xfer_ch=sel each cycle; the beat counter increments; xfer_last=1 when beat==BURST_LEN-1; the FSM goes to RELEASE after the last beat.
REQ-024 XFER lasts exactly BURST_LEN cycles, and grant is ignored throughout (no grant_err).
REQ-025 RELEASE lasts one cycle: done[sel]=1, the counter decrement is applied, xfer_valid=0, then the FSM returns to IDLE.
REQ-026 Latency from a sampled legal grant to the first beat is 1 cycle. Back-to-back grants are possible: a grant seen in the first IDLE cycle after RELEASE is accepted.
REQ-027 Other channels keep req asserted during XFER and RELEASE, and their counters keep accepting job_in.
REQ-028 In the sel channel, req drops in the first XFER cycle. It reasserts in IDLE only if that channel's pending count is still nonzero after the decrement.
REQ-029 full, xfer_valid, xfer_ch, xfer_last and req are combinational decodes of registers; done, drop and grant_err are registered pulses.

Reset
REQ-030 While reset=0, the FSM is IDLE, all pending counters and the beat counter are 0, and sel=0.
REQ-031 While reset=0, outputs are: req=0, xfer_valid=0, xfer_ch=0, xfer_last=0, done=0, full=0, drop=0, grant_err=0.
REQ-032 Reset asserted mid-XFER aborts the burst with no done pulse, and all queued jobs are discarded.
REQ-033 The first job_in is accepted on the first rising edge after reset deasserts.

Verification
REQ-034 Scenario 1: reset, then job_in=0001 for one cycle; next cycle req=0001; grant=0001 for one cycle -> xfer_valid high for 4 cycles with xfer_ch=0 and xfer_last on the 4th beat, then done=0001 for one cycle, then req=0000.
REQ-035 Scenario 2: 8 job_in pulses on channel 2 with CNT_W=3 -> full[2]=1 after the 7th pulse, one drop[2] pulse for the 8th, and the counter stays at 7.
REQ-036 Scenario 3: channel 1 pending=1, job_in[1] in its RELEASE cycle -> the count remains 1 and req[1] reasserts in IDLE.
REQ-037 Scenario 4: grant=0110 in IDLE, then grant=1000 with req[3]=0 -> grant_err pulses twice, the FSM stays in IDLE, and no beats occur.
REQ-038 Scenario 5: channels 0 and 3 pending, grant=1000 then grant=0001 in the first IDLE cycle after the channel-3 RELEASE -> two bursts separated by exactly one RELEASE cycle and one IDLE cycle.
REQ-039 Scenario 6: reset asserted asynchronously on the 2nd XFER beat -> xfer_valid drops immediately, no done pulse occurs, and all counters read 0.
